// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified memory arbiter.
// Build option ARB_RR_EN selects round-robin grant instead of D-over-I.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } cli_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  function automatic cli_e other_cli(input cli_e c);
    return (c == CLI_I) ? CLI_D : CLI_I;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational winner select between I and D clients.
// ARB_RR_EN: tie goes to the client not granted last; else D wins.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  cli_e last_grant,
  output logic gnt_vld,
  output cli_e gnt_cli
);

  cli_e tie_win;

`ifdef ARB_RR_EN
  assign tie_win = other_cli(last_grant);
`else
  logic unused_last;
  assign unused_last = last_grant;
  assign tie_win     = CLI_D;
`endif

  // Resolve the pending requesters into a single winner.
  always_comb begin
    gnt_vld = i_req | d_req;
    gnt_cli = CLI_I;
    unique case (1'b1)
      (i_req & d_req):  gnt_cli = tie_win;
      (d_req & ~i_req): gnt_cli = CLI_D;
      default:          gnt_cli = CLI_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (I/D) front end for unified_mem with timeout.
// Define ARB_RR_EN for round-robin instead of fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_re,
  output logic [DATA_W-1:0] i_rd_data,
  output logic              i_ack,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rd_data,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rdy,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state;
  cli_e             owner;
  op_e              op;
  logic [CNT_W-1:0] wait_cnt;

  logic d_req;
  logic gnt_vld;
  cli_e gnt_cli;
  cli_e last_grant;

  assign d_req = d_re | d_we;

  mem_arb_grant u_grant (
    .i_req      (i_re),
    .d_req      (d_req),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_cli    (gnt_cli)
  );

`ifdef ARB_RR_EN
  // Remember the most recent winner so ties alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= CLI_I;
    end else if (state == IDLE && gnt_vld) begin
      last_grant <= gnt_cli;
    end
  end
`else
  assign last_grant = CLI_I;
`endif

  // Transaction FSM: grant, strobe, wait for rdy or timeout, ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= CLI_I;
      op        <= OP_RD;
      wait_cnt  <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rd_data <= '0;
      d_rd_data <= '0;
      mem_err   <= 1'b0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner <= gnt_cli;
            state <= ISSUE;
            if (gnt_cli == CLI_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              op        <= d_we ? OP_WR : OP_RD;
              mem_we    <= d_we;
              mem_re    <= ~d_we;
            end else begin
              mem_addr <= i_addr;
              op       <= OP_RD;
              mem_re   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_rdy) begin
            if (op == OP_RD) begin
              if (owner == CLI_D) begin
                d_rd_data <= mem_rd_data;
              end else begin
                i_rd_data <= mem_rd_data;
              end
            end
            i_ack <= (owner == CLI_I);
            d_ack <= (owner == CLI_D);
            state <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            wait_cnt <= wait_cnt + CNT_ONE;
            mem_err  <= 1'b1;
            if (op == OP_RD) begin
              if (owner == CLI_D) begin
                d_rd_data <= '0;
              end else begin
                i_rd_data <= '0;
              end
            end
            i_ack <= (owner == CLI_I);
            d_ack <= (owner == CLI_D);
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random checks of mem_arbiter against a
// bench-side memory model and an expected-contents scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int MW     = 15;
  localparam int LAT    = 5;
  localparam int TO_LAT = 2 + MW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_re = 1'b0;
  logic [DW-1:0] i_rd_data;
  logic          i_ack;
  logic [AW-1:0] d_addr = '0;
  logic          d_re = 1'b0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rd_data;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rdy = 1'b0;
  logic          mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (i_addr),
    .i_re        (i_re),
    .i_rd_data   (i_rd_data),
    .i_ack       (i_ack),
    .d_addr      (d_addr),
    .d_re        (d_re),
    .d_we        (d_we),
    .d_wdata     (d_wdata),
    .d_rd_data   (d_rd_data),
    .d_ack       (d_ack),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rd_data (mem_rd_data),
    .mem_rdy     (mem_rdy),
    .mem_err     (mem_err)
  );

  // unified_mem stand-in: rdy in the 3rd cycle after the strobe cycle
  logic [DW-1:0] mem [int];
  int            cd = 0;
  int            ra = 0;
  bit            stub_hold = 1'b0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd      = 0;
      mem_rdy = 1'b0;
    end else begin
      mem_rdy     = 1'b0;
      mem_rd_data = $urandom;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !stub_hold) begin
          mem_rdy     = 1'b1;
          mem_rd_data = mem.exists(ra) ? mem[ra] : '0;
        end
      end
      if (mem_re || mem_we) begin
        cd = 3;
        ra = int'(mem_addr);
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
      end
    end
  end

  // reference model state
  logic [DW-1:0] ref_mem [int];
  bit            last_d = 1'b0;
  logic [DW-1:0] exp_i_rd = '0;
  logic [DW-1:0] exp_d_rd = '0;
  bit            exp_err = 1'b0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  function automatic bit pick_d(input bit ir, input bit dr);
`ifdef ARB_RR_EN
    if (ir && dr) return !last_d;
`else
    if (ir && dr) return 1'b1;
`endif
    return dr;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input bit drop, input bit scr, input bit to);
    bit is_d, is_wr, seen;
    int n, re_cnt, we_cnt;
    is_d  = pick_d(ir, dr | dw);
    is_wr = is_d && dw;
    if (ir) begin
      i_re = 1'b1; i_addr = a;
    end else begin
      d_re = dr; d_we = dw; d_addr = a; d_wdata = wd;
    end
    last_d = is_d;
    n = 0; seen = 1'b0; re_cnt = 0; we_cnt = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      chk("ack_excl", i_ack & d_ack, 0);
      if (n == 1) begin
        chk("strobe_addr", mem_addr, a);
        if (is_wr) chk("strobe_wdata", mem_wdata, wd);
        if (scr) begin
          i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        end
        if (drop) begin
          i_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
        end
      end
      if (n == 3) chk("addr_hold", mem_addr, a);
      if (i_ack || d_ack) seen = 1'b1;
    end
    if (to) exp_err = 1'b1;
    if (!is_wr) begin
      if (is_d) exp_d_rd = to ? '0 : ref_rd(a);
      else      exp_i_rd = to ? '0 : ref_rd(a);
    end
    if (is_wr) ref_mem[int'(a)] = wd;
    chk("ack_seen", seen, 1);
    chk("latency", n, to ? TO_LAT : LAT);
    chk("d_ack", d_ack, is_d);
    chk("i_ack", i_ack, !is_d);
    chk("re_pulses", re_cnt, !is_wr);
    chk("we_pulses", we_cnt, is_wr);
    chk("i_rd_data", i_rd_data, exp_i_rd);
    chk("d_rd_data", d_rd_data, exp_d_rd);
    chk("mem_err", mem_err, exp_err);
    i_re = 1'b0; d_re = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("ack_pulse", i_ack | d_ack, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ex_d, seen;
    int n;
    logic [AW-1:0] a;
    mem[32'h0040]     = 32'h1234_5678;
    ref_mem[32'h0040] = 32'h1234_5678;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", {i_ack, d_ack, mem_re, mem_we, mem_err}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_ird", i_rd_data, 0);
    chk("rst_drd", d_rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single I read, D write then read
    txn(1, 0, 0, 16'h0040, '0, 0, 0, 0);
    txn(0, 0, 1, 16'h0100, 32'hCAFE_F00D, 0, 0, 0);
    txn(0, 1, 0, 16'h0100, '0, 0, 0, 0);
    // d_re and d_we together act as a write
    txn(0, 1, 1, 16'h0300, 32'hA5A5_A5A5, 0, 0, 0);
    txn(0, 1, 0, 16'h0300, '0, 1, 1, 0);

    // both clients hold requests continuously
    i_re = 1'b1; i_addr = 16'h0040;
    d_re = 1'b1; d_addr = 16'h0300;
    for (int k = 0; k < 4; k++) begin
      ex_d   = pick_d(1'b1, 1'b1);
      last_d = ex_d;
      n = 0; seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        chk("hold_excl", i_ack & d_ack, 0);
        if (i_ack || d_ack) seen = 1'b1;
      end
      if (ex_d) exp_d_rd = ref_rd(16'h0300);
      else      exp_i_rd = ref_rd(16'h0040);
      chk("hold_lat", n, (k == 0) ? LAT : LAT + 1);
      chk("hold_d_ack", d_ack, ex_d);
      chk("hold_i_ack", i_ack, !ex_d);
      chk("hold_ird", i_rd_data, exp_i_rd);
      chk("hold_drd", d_rd_data, exp_d_rd);
    end
    i_re = 1'b0; d_re = 1'b0;
    @(negedge clk);

    // random single-client traffic
    for (int k = 0; k < 24; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      a    = 16'h0100 + AW'($urandom_range(0, 7));
      txn(kind == 0, kind == 1 || kind == 3, kind >= 2, a, $urandom,
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
    end

    // stuck memory -> timeout, sticky error
    stub_hold = 1'b1;
    txn(1, 0, 0, 16'h0040, '0, 0, 0, 1);
    stub_hold = 1'b0;
    txn(0, 1, 0, 16'h0100, '0, 0, 0, 0);

    // reset in the middle of a D write
    d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    d_we  = 1'b0;
    #1;
    chk("mid_rst_ctl", {i_ack, d_ack, mem_re, mem_we, mem_err}, 0);
    chk("mid_rst_maddr", mem_addr, 0);
    chk("mid_rst_mwdata", mem_wdata, 0);
    chk("mid_rst_ird", i_rd_data, 0);
    chk("mid_rst_drd", d_rd_data, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", i_ack | d_ack, 0);
    end
    rst_n    = 1'b1;
    last_d   = 1'b0;
    exp_err  = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
    @(negedge clk);
    chk("post_rst_ack", i_ack | d_ack, 0);
    txn(1, 0, 0, 16'h0040, '0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
